// File: rtl/icache_dm.sv
// icache_dm: direct-mapped one-word-per-frame instruction cache with a two-state fill FSM.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
`default_nettype none

module icache_dm #(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = 30 - IW;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]    r_state;
  logic [31:0]   r_miss_addr;
  logic [NSETS-1:0] r_valid;
  logic [TW-1:0] r_tag  [NSETS];
  logic [31:0]   r_data [NSETS];

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_fill_idx;
  logic [TW-1:0] w_fill_tag;
  logic          w_hit;
  logic          w_start_miss;
  logic          w_fill;
  logic          w_unused_offset;

  assign w_idx           = imemaddr[IW+1:2];
  assign w_tag           = imemaddr[31:IW+2];
  assign w_fill_idx      = r_miss_addr[IW+1:2];
  assign w_fill_tag      = r_miss_addr[31:IW+2];
  assign w_unused_offset = &{1'b0, imemaddr[1:0]};

  // Hits are only reported from IDLE so a frame under fill is never returned early.
  assign w_hit        = (r_state == IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_start_miss = (r_state == IDLE) && imemREN && !w_hit;
  assign w_fill       = (r_state == FETCH) && !iwait;

  assign ihit     = w_hit;
  assign imemload = w_hit ? r_data[w_idx] : 32'h0;
  assign iREN     = (r_state == FETCH);
  assign iaddr    = (r_state == FETCH) ? r_miss_addr : 32'h0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_miss_addr <= 32'h0;
      r_valid     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start_miss) begin
            r_miss_addr <= {imemaddr[31:2], 2'b00};
            r_state     <= FETCH;
          end
        end
        FETCH: begin
          if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_state             <= IDLE;
          end else if (!imemREN) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data need no reset; their validity is governed entirely by r_valid.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_start_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm (NSETS=16).
`default_nettype none

module tb_icache_dm;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iwait;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks;
  int errors;

  icache_dm #(.NSETS(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iwait      (iwait),
    .iload      (iload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    tick();
    tick();

    // Reset state
    check("rst_ihit", {31'h0, ihit}, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iREN", {31'h0, iREN}, 32'h0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);

    // Cold miss on 0x40
    RST      = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #1;
    check("cold_ihit", {31'h0, ihit}, 32'h0);
    check("cold_iREN_idle", {31'h0, iREN}, 32'h0);
    tick();
    #1;
    check("cold_iREN", {31'h0, iREN}, 32'h1);
    check("cold_iaddr", iaddr, 32'h0000_0040);
    check("cold_ihit_fetch", {31'h0, ihit}, 32'h0);
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    tick();
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    check("cold_hit", {31'h0, ihit}, 32'h1);
    check("cold_load", imemload, 32'hDEAD_BEEF);
    check("cold_iREN_done", {31'h0, iREN}, 32'h0);
    check("cold_iaddr_done", iaddr, 32'h0);

    // Second miss on 0x80 (index 0, tag 2), then three hit cycles
    imemaddr = 32'h0000_0080;
    #1;
    check("c80_ihit", {31'h0, ihit}, 32'h0);
    tick();
    #1;
    check("c80_iaddr", iaddr, 32'h0000_0080);
    iwait = 1'b0;
    iload = 32'h1111_1111;
    tick();
    iwait = 1'b1;
    #1;
    check("c80_hit", {31'h0, ihit}, 32'h1);
    check("c80_load", imemload, 32'h1111_1111);
    tick();
    tick();
    tick();
    #1;
`ifdef ICACHE_STATS_EN
    check("stats_hit", hit_count, 32'd3);
    check("stats_miss", miss_count, 32'd2);
`else
    check("stats_hit", hit_count, 32'd0);
    check("stats_miss", miss_count, 32'd0);
`endif

    // Conflict: 0x40 was evicted by 0x80
    imemaddr = 32'h0000_0040;
    #1;
    check("conf_ihit", {31'h0, ihit}, 32'h0);
    tick();
    #1;
    check("conf_iaddr", iaddr, 32'h0000_0040);
    iwait = 1'b0;
    iload = 32'hCAFE_F00D;
    tick();
    iwait = 1'b1;
    #1;
    check("conf_hit", {31'h0, ihit}, 32'h1);
    check("conf_load", imemload, 32'hCAFE_F00D);

    // Slow memory on 0x104
    imemaddr = 32'h0000_0104;
    #1;
    check("slow_ihit", {31'h0, ihit}, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("slow_iREN", {31'h0, iREN}, 32'h1);
      check("slow_iaddr", iaddr, 32'h0000_0104);
      check("slow_ihit_fetch", {31'h0, ihit}, 32'h0);
      tick();
    end
    iwait = 1'b0;
    iload = 32'h1234_5678;
    tick();
    iwait = 1'b1;
    #1;
    check("slow_hit", {31'h0, ihit}, 32'h1);
    check("slow_load", imemload, 32'h1234_5678);

    // Abandon fetch of 0x200
    imemaddr = 32'h0000_0200;
    #1;
    check("ab_ihit", {31'h0, ihit}, 32'h0);
    tick();
    #1;
    check("ab_iREN", {31'h0, iREN}, 32'h1);
    imemREN = 1'b0;
    tick();
    #1;
    check("ab_iREN_drop", {31'h0, iREN}, 32'h0);
    imemREN = 1'b1;
    #1;
    check("ab_refetch_miss", {31'h0, ihit}, 32'h0);

    // Asynchronous reset during FETCH of 0x200
    tick();
    #1;
    check("rf_iREN", {31'h0, iREN}, 32'h1);
    RST = 1'b1;
    #1;
    check("rf_iREN_drop", {31'h0, iREN}, 32'h0);
    check("rf_iaddr", iaddr, 32'h0);
    check("rf_ihit", {31'h0, ihit}, 32'h0);
    tick();
    RST      = 1'b0;
    imemaddr = 32'h0000_0040;
    #1;
    check("rf_0x40_miss", {31'h0, ihit}, 32'h0);

    // Fill completes when imemREN drops in the same cycle iwait falls
    tick();
    #1;
    check("drop_iaddr", iaddr, 32'h0000_0040);
    imemREN = 1'b0;
    iwait   = 1'b0;
    iload   = 32'hA5A5_A5A5;
    tick();
    iwait   = 1'b1;
    imemREN = 1'b1;
    #1;
    check("drop_hit", {31'h0, ihit}, 32'h1);
    check("drop_load", imemload, 32'hA5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter: NSETS, 16, number of direct-mapped one-word frames; power of two, 2..256.
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  CLK  in  1  single clock, rising edge
  RST  in  1  reset, asynchronous, active-high
  imemREN  in  1  datapath instruction fetch request
  imemaddr  in  32  datapath fetch byte address
  ihit  out  1  fetch satisfied this cycle
  imemload  out  32  fetched instruction
  iwait  in  1  memory control busy, high = not done
  iload  in  32  instruction word from memory control
  iREN  out  1  fill request to memory control
  iaddr  out  32  fill word address
  hit_count  out  32  hit counter (see Configuration)
  miss_count  out  32  miss counter (see Configuration)
REQ-003 SHALL use one clock, CLK; reset RST is asynchronous and active-high.

Function
REQ-004 SHALL split the address as offset [1:0] (ignored), index [IW+1:2] where IW=log2(NSETS), and tag [31:IW+2].
REQ-005 SHALL hold one valid bit, one tag and one 32-bit data word per frame.
REQ-006 SHALL implement FSM states IDLE and FETCH.
REQ-007 In IDLE, ihit SHALL be combinational: imemREN and valid[index] and stored tag equals address tag; zero-cycle hit latency.
REQ-008 imemload SHALL equal data[index] when ihit=1, else 32'h0.
REQ-009 IDLE with imemREN=1 and no hit SHALL latch {imemaddr[31:2],2'b00} as the miss address and move to FETCH at the next edge.
REQ-010 In FETCH, iREN SHALL be 1 and iaddr SHALL equal the latched miss address; in IDLE, iREN=0 and iaddr=32'h0.
REQ-011 In FETCH, ihit SHALL be 0 regardless of array contents.
REQ-012 In FETCH with iwait=0, the edge SHALL write iload, latched tag and valid=1 into the latched index and return to IDLE.
REQ-013 Miss latency: ihit SHALL assert the cycle after the fill edge if imemaddr is unchanged (total = memory latency + 1 cycle).
REQ-014 In FETCH with imemREN=0 and iwait=1, the FSM SHALL return to IDLE at the next edge without writing the frame.
REQ-015 In FETCH with imemREN=0 and iwait=0 simultaneously, the fill SHALL complete (write frame) and return to IDLE.
REQ-016 If imemaddr changes during FETCH, the fill SHALL still use the latched address; IDLE re-evaluates the new address afterwards.
REQ-017 A fill SHALL overwrite the frame unconditionally (conflict eviction, no write-back).
REQ-018 iaddr and iREN SHALL be stable for every cycle of a FETCH with iwait=1.

Reset
REQ-019 While RST=1, all valid bits SHALL clear and the FSM SHALL be IDLE, asynchronously.
REQ-020 Reset values: ihit=0, imemload=0, iREN=0, iaddr=0, hit_count=0, miss_count=0; tag/data contents don't-care.
REQ-021 RST asserted mid-FETCH SHALL drop iREN in the same cycle and discard the pending fill.

Configuration
REQ-022 Macro ICACHE_STATS_EN SHALL control the statistics counters.
REQ-023 With ICACHE_STATS_EN defined: hit_count SHALL increment on each edge where ihit=1; miss_count SHALL increment on each IDLE->FETCH transition; both saturate at 32'hFFFF_FFFF.
REQ-024 Without ICACHE_STATS_EN: hit_count and miss_count SHALL be tied to 32'h0 with no counter flops; all other behaviour identical.

Verification
REQ-025 Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040 -> ihit=0, next cycle iREN=1 iaddr=0x40; drive iwait=0 iload=0xDEADBEEF -> next cycle ihit=1, imemload=0xDEADBEEF, iREN=0.
REQ-026 Conflict: fill 0x40 (index 0, tag 1), then fetch 0x80 (index 0, tag 2) -> miss, fill replaces; re-fetch 0x40 -> miss again.
REQ-027 Slow memory: hold iwait=1 for 5 cycles during FETCH of 0x104 -> iREN=1 and iaddr=0x104 all 5 cycles, ihit=0; release -> hit next cycle.
REQ-028 Abandon: drop imemREN in FETCH with iwait=1 -> next cycle iREN=0; later fetch of same address misses.
REQ-029 Reset mid-FETCH: assert RST with iREN=1 -> iREN=0 immediately; after release, previously filled 0x40 misses.
REQ-030 Stats: 2 misses then 3 hit cycles -> with ICACHE_STATS_EN hit_count=3, miss_count=2; without, both read 0.
